regfile_mp: RTL and testbench

//   Parametrised multi-port register file for the next-generation datapath core.
//   - NUM_RD combinational read ports and two write ports:
//     - A: ALU/load result.
//     - B: base-register writeback.
//   - Index PC_IDX is not stored; reads of PC_IDX return the externally held PC (pc_in).
//   - Contents are cleared by a hardware sweep after reset or on request; a ready flag gates use.
//

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_clr_ctrl.sv | 66 ++++++
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_NUM_RD = 3;

  typedef enum logic {CLEAR, RUN} rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, packed read ports, clear/ready handshake.
interface regfile_mp_if #(
  parameter int DATA_W = regfile_pkg::RF_DATA_W,
  parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
  parameter int NUM_RD = regfile_pkg::RF_NUM_RD
);

  logic                       clr_req;
  logic                       ready;
  logic                       we_a;
  logic [ADDR_W-1:0]          wa_a;
  logic [DATA_W-1:0]          wd_a;
  logic                       we_b;
  logic [ADDR_W-1:0]          wa_b;
  logic [DATA_W-1:0]          wd_b;
  logic [DATA_W-1:0]          pc_in;
  logic [NUM_RD*ADDR_W-1:0]   ra;
  logic [NUM_RD*DATA_W-1:0]   rd;
  logic                       wr_clash;

  modport master (
    output clr_req, we_a, wa_a, wd_a, we_b, wa_b, wd_b, pc_in, ra,
    input  ready, rd, wr_clash
  );

  modport slave (
    input  clr_req, we_a, wa_a, wd_a, we_b, wa_b, wd_b, pc_in, ra,
    output ready, rd, wr_clash
  );

endinterface

// File: rtl/regfile_clr_ctrl.sv
// Clear-sweep sequencer: walks every stored entry after reset or on request, then flags ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | write CLR_VAL to entry cnt each cycle, cnt 0..PC_IDX-1
//   RUN   | sweep done, ready=1, clr_req restarts the sweep
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  // Last stored index is PC_IDX-1, i.e. all ones with the LSB cleared.
  localparam logic [ADDR_W-1:0] LAST_IDX = {{(ADDR_W-1){1'b1}}, 1'b0};

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt == LAST_IDX) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clr_addr = cnt;
  assign ready    = (state == RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with PC-aliased top index and hardware clear sweep.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W  = RF_DATA_W,
  parameter int                ADDR_W  = RF_ADDR_W,
  parameter int                NUM_RD  = RF_NUM_RD,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam logic [ADDR_W-1:0] PC_IDX = '1;
  localparam int                DEPTH  = (1 << ADDR_W) - 1;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              a_ok, b_ok;
  logic              wr_clash_q;

  logic [DATA_W-1:0] rf [DEPTH];

  regfile_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign bus.ready = ready;

  assign a_ok = ready & bus.we_a & (bus.wa_a != PC_IDX);
  assign b_ok = ready & bus.we_b & (bus.wa_b != PC_IDX);

  // Port B is written last so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      rf[clr_addr] <= CLR_VAL;
    end else begin
      if (a_ok) rf[bus.wa_a] <= bus.wd_a;
      if (b_ok) rf[bus.wa_b] <= bus.wd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_clash_q <= 1'b0;
    else        wr_clash_q <= a_ok & b_ok & (bus.wa_a == bus.wa_b);
  end

  assign bus.wr_clash = wr_clash_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] val;

    assign idx = bus.ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      val = CLR_VAL;
      if (idx == PC_IDX) begin
        val = bus.pc_in;
      end else if (ready) begin
        val = rf[idx];
`ifdef REGFILE_BYPASS_EN
        if (a_ok && (bus.wa_a == idx)) val = bus.wd_a;
        if (b_ok && (bus.wa_b == idx)) val = bus.wd_b;
`endif
      end
    end

    assign bus.rd[i*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, write priority, PC aliasing, clear and reset restart.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int PC = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [PC];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Drive the same index on every read port, queue the expectation, compare after settling.
  task automatic read_check(input string tag, input int idx, input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    for (int i = 0; i < NR; i++) begin
      bus.ra[i*AW +: AW] = AW'(idx);
      exp_q.push_back(exp);
    end
    #1;
    for (int i = 0; i < NR; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_r%0d_p%0d", tag, idx, i), bus.rd[i*DW +: DW], e);
    end
  endtask

  task automatic idle();
    bus.clr_req = 1'b0;
    bus.we_a    = 1'b0;
    bus.we_b    = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, DW'(n), DW'(exp_cycles));
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < PC; k++) begin
      @(negedge clk);
      read_check(tag, k, model[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.wa_a  = '0; bus.wd_a = '0;
    bus.wa_b  = '0; bus.wd_b = '0;
    bus.pc_in = 32'h0000_1000;
    bus.ra    = '0;
    for (int k = 0; k < PC; k++) model[k] = '0;

    // 1. reset state and initial sweep
    #1;
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_clash", {31'b0, bus.wr_clash}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_ready("sweep_after_reset", 15);
    check_all("init");
    @(negedge clk);
    read_check("pc_read", 15, 32'h0000_1000);

    // 2. port A write r3
    @(negedge clk);
    bus.we_a = 1'b1; bus.wa_a = 4'd3; bus.wd_a = 32'hDEAD_BEEF;
    read_check("wr_cycle", 3, BYP ? 32'hDEAD_BEEF : 32'h0);
    @(negedge clk);
    idle();
    model[3] = 32'hDEAD_BEEF;
    read_check("wr_after", 3, 32'hDEAD_BEEF);

    // 3. clash on r5, then disjoint r5/r6
    @(negedge clk);
    bus.we_a = 1'b1; bus.wa_a = 4'd5; bus.wd_a = 32'h11;
    bus.we_b = 1'b1; bus.wa_b = 4'd5; bus.wd_b = 32'h22;
    read_check("clash_cycle", 5, BYP ? 32'h22 : 32'h0);
    check("clash_pre", {31'b0, bus.wr_clash}, 32'd0);
    @(negedge clk);
    idle();
    read_check("clash_val", 5, 32'h22);
    check("clash_pulse", {31'b0, bus.wr_clash}, 32'd1);
    @(negedge clk);
    #1;
    check("clash_end", {31'b0, bus.wr_clash}, 32'd0);
    bus.we_a = 1'b1; bus.wa_a = 4'd5; bus.wd_a = 32'h33;
    bus.we_b = 1'b1; bus.wa_b = 4'd6; bus.wd_b = 32'h44;
    @(negedge clk);
    idle();
    model[5] = 32'h33; model[6] = 32'h44;
    read_check("disj_a", 5, 32'h33);
    read_check("disj_b", 6, 32'h44);
    check("disj_clash", {31'b0, bus.wr_clash}, 32'd0);

    // 4. writes to PC index are dropped, no clash flagged
    @(negedge clk);
    bus.we_a = 1'b1; bus.wa_a = 4'd15; bus.wd_a = 32'h55;
    bus.we_b = 1'b1; bus.wa_b = 4'd15; bus.wd_b = 32'h66;
    @(negedge clk);
    idle();
    read_check("pc_wr", 15, 32'h0000_1000);
    check("pc_clash", {31'b0, bus.wr_clash}, 32'd0);
    bus.pc_in = 32'h0000_2000;
    read_check("pc_track", 15, 32'h0000_2000);
    check_all("after_pc");

    // 5. requested clear with writes held during the sweep
    @(negedge clk);
    bus.we_a = 1'b1; bus.wa_a = 4'd7; bus.wd_a = 32'h7;
    @(negedge clk);
    idle();
    model[7] = 32'h7;
    read_check("r7_set", 7, 32'h7);
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    #1;
    check("clr_ready_drop", {31'b0, bus.ready}, 32'd0);
    read_check("clr_masked", 3, 32'h0);
    read_check("clr_pc", 15, 32'h0000_2000);
    bus.we_a = 1'b1; bus.wa_a = 4'd7; bus.wd_a = 32'h99;
    bus.we_b = 1'b1; bus.wa_b = 4'd8; bus.wd_b = 32'hAB;
    bus.clr_req = 1'b1;
    repeat (5) @(negedge clk);
    bus.clr_req = 1'b0;
    #1;
    wait_ready("sweep_after_req", 10);
    idle();
    for (int k = 0; k < PC; k++) model[k] = '0;
    check_all("after_clr");

    // 6. reset asserted at sweep cnt=8 restarts the sweep
    @(negedge clk);
    bus.we_a = 1'b1; bus.wa_a = 4'd9; bus.wd_a = 32'h9;
    @(negedge clk);
    idle();
    read_check("r9_set", 9, 32'h9);
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, bus.ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_ready("sweep_restart", 15);
    @(negedge clk);
    read_check("r9_cleared", 9, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
